// File: rtl/inv_sqrt_iter.sv
// Purpose: iterative FP32 fast inverse square root, y ~= 1/sqrt(x), one operand in flight.
// Latency: result valid 2+4*n_eff cycles after accept (special operands: 1 cycle).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid/in_ready         operand handshake; in_data = x (FP32), n_iter = Newton steps
//   out_valid/out_ready       result handshake; out_data = y (FP32), held while stalled
//   busy                      high from accept until the result is taken
module inv_sqrt_iter #(
   parameter int          ITER_MAX = 2,
   parameter logic [31:0] MAGIC    = 32'h5F3759DF,
   parameter int          IW       = $clog2(ITER_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_data,
   input  logic [IW-1:0] n_iter,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic          busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SEED   = 3'd1;
   localparam logic [2:0] MUL_YY = 3'd2;
   localparam logic [2:0] MUL_HX = 3'd3;
   localparam logic [2:0] SUB    = 3'd4;
   localparam logic [2:0] MUL_Y  = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   localparam logic [31:0]   QNAN       = 32'h7FC00000;
   localparam logic [31:0]   PINF       = 32'h7F800000;
   localparam logic [31:0]   THREE_HALF = 32'h3FC00000;
   localparam logic [IW-1:0] ITER_MAX_W = IW'(ITER_MAX);

   // Truncating FP32 multiply; subnormals flush to +0, overflow saturates to inf.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic              s;
      logic [7:0]        ea, eb;
      logic [47:0]       p;
      logic [22:0]       m;
      logic signed [10:0] e;
      logic [31:0]       r;
      s  = a[31] ^ b[31];
      ea = a[30:23];
      eb = b[30:23];
      p  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e  = $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd127;
      m  = p[45:23];
      r  = 32'h0;
      if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0))
         r = QNAN;
      else if (ea == 8'hFF || eb == 8'hFF)
         r = (ea == 8'd0 || eb == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
      else if (ea == 8'd0 || eb == 8'd0)
         r = 32'h0;
      else begin
         if (p[47]) begin
            e = e + 11'sd1;
            m = p[46:24];
         end
         if (e >= 11'sd255)
            r = {s, 8'hFF, 23'd0};
         else if (e <= 11'sd0)
            r = 32'h0;
         else
            r = {s, e[7:0], m};
      end
      return r;
   endfunction

   // Truncating FP32 add with three guard bits; exponent gaps above 25 return the larger operand.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]       big, sml, r;
      logic [7:0]        eb, d;
      logic [26:0]       mb, ms, diff, norm;
      logic [27:0]       sum;
      logic [22:0]       mant;
      logic [4:0]        pos, sh;
      logic signed [9:0] e;
      r = 32'h0; big = a; sml = b; pos = 5'd0; sh = 5'd0; e = 10'sd0;
      mb = 27'd0; ms = 27'd0; diff = 27'd0; norm = 27'd0; sum = 28'd0;
      eb = 8'd0; d = 8'd0; mant = 23'd0;
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
         r = QNAN;
      else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
         r = (a[31] != b[31]) ? QNAN : a;
      else if (a[30:23] == 8'hFF)
         r = a;
      else if (b[30:23] == 8'hFF)
         r = b;
      else if (a[30:23] == 8'd0 && b[30:23] == 8'd0)
         r = 32'h0;
      else if (a[30:23] == 8'd0)
         r = b;
      else if (b[30:23] == 8'd0)
         r = a;
      else begin
         if (a[30:0] < b[30:0]) begin
            big = b;
            sml = a;
         end
         eb = big[30:23];
         d  = eb - sml[30:23];
         if (d > 8'd25)
            r = big;
         else begin
            mb = {1'b1, big[22:0], 3'b000};
            ms = {1'b1, sml[22:0], 3'b000} >> d;
            if (big[31] == sml[31]) begin
               sum  = {1'b0, mb} + {1'b0, ms};
               e    = $signed({2'b0, eb}) + (sum[27] ? 10'sd1 : 10'sd0);
               mant = sum[27] ? sum[26:4] : sum[25:3];
               r    = (e >= 10'sd255) ? {big[31], 8'hFF, 23'd0} : {big[31], e[7:0], mant};
            end else begin
               diff = mb - ms;
               if (diff != 27'd0) begin
                  // Later (higher) set bits overwrite, leaving the leading-one position.
                  for (int i = 0; i < 27; i++)
                     if (diff[i]) pos = 5'(i);
                  sh   = 5'd26 - pos;
                  norm = diff << sh;
                  e    = $signed({2'b0, eb}) - $signed({5'b0, sh});
                  r    = (e <= 10'sd0) ? 32'h0 : {big[31], e[7:0], norm[25:3]};
               end
            end
         end
      end
      return r;
   endfunction

   logic [2:0]    state;
   logic [31:0]   x_r, hx, y, t;
   logic [IW-1:0] k, n_eff, n_sat, k_nxt;
   logic [31:0]   mul_a, mul_b, mul_p, sub_r, spec_val;
   logic          is_special;

   assign in_ready = rst && (state == IDLE);
   assign busy     = (state != IDLE);
   assign n_sat    = (n_iter > ITER_MAX_W) ? ITER_MAX_W : n_iter;
   assign k_nxt    = k + 1'b1;

   // Classify the incoming operand; only non-negative normals go through Newton.
   always_comb begin
      is_special = 1'b1;
      spec_val   = QNAN;
      if (in_data[30:23] == 8'd0)
         spec_val = PINF;
      else if (in_data[30:23] == 8'hFF)
         spec_val = (in_data[22:0] == 23'd0 && !in_data[31]) ? 32'h0 : QNAN;
      else if (in_data[31])
         spec_val = QNAN;
      else
         is_special = 1'b0;
   end

   // One multiplier shared across the three multiply states.
   always_comb begin
      mul_a = y;
      mul_b = y;
      case (state)
         MUL_HX:  begin mul_a = t; mul_b = hx; end
         MUL_Y:   begin mul_a = t; mul_b = y;  end
         default: begin mul_a = y; mul_b = y;  end
      endcase
   end

   assign mul_p = fmul(mul_a, mul_b);
   assign sub_r = fadd(THREE_HALF, {~t[31], t[30:0]});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         x_r       <= 32'h0;
         hx        <= 32'h0;
         y         <= 32'h0;
         t         <= 32'h0;
         k         <= '0;
         n_eff     <= '0;
         out_valid <= 1'b0;
         out_data  <= 32'h0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               x_r   <= in_data;
               n_eff <= n_sat;
               k     <= '0;
               if (is_special) begin
                  y     <= spec_val;
                  state <= DONE;
               end else
                  state <= SEED;
            end
            SEED: begin
               y     <= MAGIC - (x_r >> 1);
               hx    <= (x_r[30:23] <= 8'd1) ? 32'h0 : {x_r[31], x_r[30:23] - 8'd1, x_r[22:0]};
               state <= (n_eff == '0) ? DONE : MUL_YY;
            end
            MUL_YY: begin t <= mul_p; state <= MUL_HX; end
            MUL_HX: begin t <= mul_p; state <= SUB;    end
            SUB:    begin t <= sub_r; state <= MUL_Y;  end
            MUL_Y: begin
               y     <= mul_p;
               k     <= k_nxt;
               state <= (k_nxt == n_eff) ? DONE : MUL_YY;
            end
            DONE: begin
               // out_valid rises on the first edge in DONE, so entry itself costs one cycle.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= y;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sqrt_iter.sv
module tb_inv_sqrt_iter;

   localparam int          ITER_MAX = 2;
   localparam int          IW       = 2;
   localparam logic [31:0] MAGIC    = 32'h5F3759DF;
   localparam logic [31:0] QNAN     = 32'h7FC00000;
   localparam logic [31:0] PINF     = 32'h7F800000;
   localparam real         TOL      = 1.0 / 1048576.0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = 32'h0;
   logic [IW-1:0] n_iter = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_data;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_sqrt_iter #(.ITER_MAX(ITER_MAX), .MAGIC(MAGIC)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .n_iter(n_iter),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic real rabs(input real v);
      return (v < 0.0) ? -v : v;
   endfunction

   function automatic real b2r(input logic [31:0] b);
      real r;
      int  e;
      e = int'(b[30:23]);
      if (e == 0) return 0.0;
      r = 1.0 + $itor(b[22:0]) / 8388608.0;
      while (e > 127) begin r = r * 2.0; e--; end
      while (e < 127) begin r = r / 2.0; e++; end
      return b[31] ? -r : r;
   endfunction

   // Reference: integer seed, then ideal real-valued Newton steps.
   function automatic real model_y(input logic [31:0] x, input int n);
      real y, xr;
      logic [31:0] seed;
      seed = MAGIC - (x >> 1);
      y    = b2r(seed);
      xr   = b2r(x);
      for (int i = 0; i < n; i++) y = y * (1.5 - 0.5 * xr * y * y);
      return y;
   endfunction

   function automatic logic [31:0] special_want(input logic [31:0] x);
      if (x[30:23] == 8'd0) return PINF;
      if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return QNAN;
      if (x[30:23] == 8'hFF) return x[31] ? QNAN : 32'h0;
      return QNAN;
   endfunction

   // Drives one operand from IDLE, holds the result for 'hold' cycles, then takes it.
   task automatic run_op(input logic [31:0] x, input int n, input int hold,
                         output logic [31:0] res, output int lat);
      int bad;
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      in_data  = x;
      n_iter   = IW'(n);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      n_iter   = IW'($urandom);
      check("busy_after_accept", busy, 1);
      check("in_ready_busy", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("out_valid_seen", out_valid, 1);
      res = out_data;
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         @(negedge clk);
         if (!out_valid || out_data !== res || in_ready) bad++;
      end
      check("hold_stable", bad, 0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
      check("in_ready_after", in_ready, 1);
      check("busy_after", busy, 0);
   endtask

   task automatic do_normal(input string tag, input logic [31:0] x, input int n, input int hold);
      logic [31:0] res;
      int  lat, ne;
      real want, got;
      logic ok;
      ne = (n > ITER_MAX) ? ITER_MAX : n;
      run_op(x, n, hold, res, lat);
      check({tag, "_lat"}, lat, 2 + 4 * ne);
      if (ne == 0)
         check({tag, "_seed"}, res, MAGIC - (x >> 1));
      else begin
         want = model_y(x, ne);
         got  = b2r(res);
         ok   = (rabs(got - want) <= TOL * rabs(want));
         if (!ok) $display("  %s: x=%h n=%0d result %h (%g), model %g", tag, x, ne, res, got, want);
         check({tag, "_val"}, ok, 1);
      end
   endtask

   task automatic do_special(input string tag, input logic [31:0] x, input int hold);
      logic [31:0] res;
      int lat;
      run_op(x, $urandom_range(3, 0), hold, res, lat);
      check({tag, "_lat"}, lat, 1);
      check({tag, "_val"}, res, special_want(x));
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] sp [8];
      logic [7:0]  ex;
      int lat;
      sp = '{32'h00000000, 32'h80000000, 32'h00000123, 32'h7F800000,
             32'hFF800000, 32'h7FC00001, 32'hBF800000, 32'hC2F60000};

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_release_in_ready", in_ready, 1);

      // Directed cases
      do_normal("one_n0", 32'h3F800000, 0, 0);
      check("one_n0_exact", out_data, 32'h3F7759DF);
      do_normal("one_n1", 32'h3F800000, 1, 0);
      run_op(32'h40800000, 2, 0, res, lat);
      check("four_n2_acc", rabs(b2r(res) - 0.5) < 0.5e-5, 1);
      do_normal("four_sat", 32'h40800000, 3, 0);
      do_special("sp_zero", 32'h00000000, 0);
      do_special("sp_neg1", 32'hBF800000, 0);
      do_special("sp_pinf", 32'h7F800000, 0);
      do_special("sp_nan", 32'h7FC00001, 0);
      do_normal("bp_hold", 32'h41200000, 2, 10);

      // Reset during the MUL_HX cycle
      in_valid = 1'b1;
      in_data  = 32'h3F800000;
      n_iter   = 2'd2;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_out_data", out_data, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_normal("post_rst", 32'h3F800000, 0, 0);
      check("post_rst_exact", out_data, 32'h3F7759DF);

      // Randomized operands
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(9, 0) < 8) begin
            ex = 8'($urandom_range(190, 64));
            do_normal("rnd", {1'b0, ex, 23'($urandom)}, $urandom_range(3, 0), $urandom_range(3, 0));
         end else
            do_special("rnd_sp", sp[$urandom_range(7, 0)], $urandom_range(3, 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
